// File: rtl/fp32_mac_ctrl.sv
// fp32_mac_ctrl: one-packet-in-flight controller RX operands -> MAC issue -> result -> TX.
// Optional macro FP32_MAC_CTRL_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES and sends a quiet NaN.
module fp32_mac_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             RX_VALID_I,
  output logic             RX_READY_O,
  input  logic [95:0]      RX_DATA_I,
  output logic             MAC_VALID_O,
  input  logic             MAC_READY_I,
  output logic [31:0]      MAC_A_O,
  output logic [31:0]      MAC_B_O,
  output logic [31:0]      MAC_C_O,
  input  logic             MAC_VALID_I,
  output logic             MAC_READY_O,
  input  logic [31:0]      MAC_RESULT_I,
  output logic             TX_VALID_O,
  input  logic             TX_READY_I,
  output logic [31:0]      TX_DATA_O,
  output logic             BUSY_O,
  output logic [CNT_W-1:0] PKT_CNT_O,
  output logic [7:0]       TIMEOUT_CNT_O
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND} state_t;

  state_t      state;
  logic [31:0] result;

  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("fp32_mac_ctrl: TIMEOUT_CYCLES must be in 2..65535");
    end
  endgenerate

`ifdef FP32_MAC_CTRL_TIMEOUT_EN
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`endif

  assign BUSY_O = (state != S_IDLE);

  // Handshake outputs are registers set on the transition into their state, so
  // RX_READY_O stays low through reset and rises on the first edge after it.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state       <= S_IDLE;
      RX_READY_O  <= 1'b0;
      MAC_VALID_O <= 1'b0;
      MAC_READY_O <= 1'b0;
      TX_VALID_O  <= 1'b0;
      MAC_A_O     <= 32'h0;
      MAC_B_O     <= 32'h0;
      MAC_C_O     <= 32'h0;
      TX_DATA_O   <= 32'h0;
      result      <= 32'h0;
      PKT_CNT_O   <= '0;
`ifdef FP32_MAC_CTRL_TIMEOUT_EN
      wait_cnt      <= 16'h0;
      TIMEOUT_CNT_O <= 8'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          RX_READY_O <= 1'b1;
          if (RX_VALID_I && RX_READY_O) begin
            MAC_A_O     <= RX_DATA_I[95:64];
            MAC_B_O     <= RX_DATA_I[63:32];
            MAC_C_O     <= RX_DATA_I[31:0];
            RX_READY_O  <= 1'b0;
            MAC_VALID_O <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (MAC_READY_I) begin
            MAC_VALID_O <= 1'b0;
            MAC_READY_O <= 1'b1;
            state       <= S_WAIT;
`ifdef FP32_MAC_CTRL_TIMEOUT_EN
            wait_cnt    <= 16'h0;
`endif
          end
        end
        S_WAIT: begin
          // A result on the expiry edge wins over the timeout.
          if (MAC_VALID_I) begin
            result      <= MAC_RESULT_I;
            MAC_READY_O <= 1'b0;
            state       <= S_SEND;
          end
`ifdef FP32_MAC_CTRL_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            result      <= QNAN;
            MAC_READY_O <= 1'b0;
            state       <= S_SEND;
            if (TIMEOUT_CNT_O != 8'hFF) TIMEOUT_CNT_O <= TIMEOUT_CNT_O + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        S_SEND: begin
          // First SEND cycle stages the result onto TX_DATA_O; valid follows.
          if (!TX_VALID_O) begin
            TX_DATA_O  <= result;
            TX_VALID_O <= 1'b1;
          end else if (TX_READY_I) begin
            TX_VALID_O <= 1'b0;
            RX_READY_O <= 1'b1;
            PKT_CNT_O  <= PKT_CNT_O + 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef FP32_MAC_CTRL_TIMEOUT_EN
  assign TIMEOUT_CNT_O = 8'h0;
`endif

endmodule

// File: tb/tb_fp32_mac_ctrl.sv
// Directed bench for fp32_mac_ctrl: transaction scoreboard plus per-cycle protocol checks.
// Define FP32_MAC_CTRL_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=8).
module tb_fp32_mac_ctrl;
`ifdef FP32_MAC_CTRL_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1024;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        rx_valid = 1'b0, mac_rdy = 1'b1, mac_vld = 1'b0, tx_ready = 1'b1;
  logic [95:0] rx_data = '0;
  logic [31:0] mac_result = '0;

  logic        rx_ready_o, mac_valid_o, mac_ready_o, tx_valid_o, busy_o;
  logic [31:0] mac_a, mac_b, mac_c, tx_data;
  logic [15:0] pkt_cnt;
  logic [7:0]  to_cnt;
  logic        w_rx_ready, w_mac_valid, w_mac_ready, w_tx_valid, w_busy;
  logic [31:0] w_a, w_b, w_c, w_tx_data;
  logic [3:0]  w_pkt_cnt;
  logic [7:0]  w_to_cnt;

  fp32_mac_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(16)) dut (
    .CLK_I(clk), .RST_I(rst), .RX_VALID_I(rx_valid), .RX_READY_O(rx_ready_o), .RX_DATA_I(rx_data),
    .MAC_VALID_O(mac_valid_o), .MAC_READY_I(mac_rdy), .MAC_A_O(mac_a), .MAC_B_O(mac_b), .MAC_C_O(mac_c),
    .MAC_VALID_I(mac_vld), .MAC_READY_O(mac_ready_o), .MAC_RESULT_I(mac_result),
    .TX_VALID_O(tx_valid_o), .TX_READY_I(tx_ready), .TX_DATA_O(tx_data),
    .BUSY_O(busy_o), .PKT_CNT_O(pkt_cnt), .TIMEOUT_CNT_O(to_cnt));

  // Narrow-counter twin on the same stimulus, so counter wrap is reached quickly.
  fp32_mac_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(4)) dut_w (
    .CLK_I(clk), .RST_I(rst), .RX_VALID_I(rx_valid), .RX_READY_O(w_rx_ready), .RX_DATA_I(rx_data),
    .MAC_VALID_O(w_mac_valid), .MAC_READY_I(mac_rdy), .MAC_A_O(w_a), .MAC_B_O(w_b), .MAC_C_O(w_c),
    .MAC_VALID_I(mac_vld), .MAC_READY_O(w_mac_ready), .MAC_RESULT_I(mac_result),
    .TX_VALID_O(w_tx_valid), .TX_READY_I(tx_ready), .TX_DATA_O(w_tx_data),
    .BUSY_O(w_busy), .PKT_CNT_O(w_pkt_cnt), .TIMEOUT_CNT_O(w_to_cnt));

  always #5 clk = ~clk;

  int checks = 0, fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard / model state
  logic [95:0] rx_q[$];
  logic [31:0] res_q[$];
  logic [31:0] exp_q[$];
  int          tx_cyc_q[$];
  int          cyc = 0, model_pkt = 0, model_to = 0, tx_count = 0;
  int          last_tx_cyc = 0, last_rx_cyc = 0, last_issue_cyc = 0;
  logic [31:0] last_tx_data = '0, held_tx = '0;
  logic [95:0] pend_op = '0, held_ops = '0;
  bit          got_res = 0, hold_tx = 0, hold_mac = 0;
  bit          rx_fire_n = 0, issue_fire_n = 0, res_fire_n = 0, tx_fire_n = 0;

  // Inputs only change at posedge+1, so values seen here are those at the next edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      model_pkt = 0;
      model_to  = 0;
      hold_tx   = 0;
      hold_mac  = 0;
    end
    chk("pkt_cnt", pkt_cnt, model_pkt % 65536);
    chk("pkt_cnt_w4", w_pkt_cnt, model_pkt % 16);
    chk("timeout_cnt", to_cnt, model_to);
    if (!rst) begin
      chk("one_channel_active", $countones({rx_ready_o, mac_valid_o, mac_ready_o, tx_valid_o}) <= 1, 1);
      if (rx_ready_o || mac_valid_o || mac_ready_o || tx_valid_o)
        chk("busy", busy_o, !rx_ready_o);
      if (hold_tx) begin
        chk("tx_hold_valid", tx_valid_o, 1);
        chk("tx_hold_data", tx_data, held_tx);
      end
      if (hold_mac) chk("mac_hold", {mac_valid_o, mac_a, mac_b, mac_c}, {1'b1, held_ops});
    end
    rx_fire_n    = !rst && rx_valid && rx_ready_o;
    issue_fire_n = !rst && mac_valid_o && mac_rdy;
    res_fire_n   = !rst && mac_vld && mac_ready_o;
    tx_fire_n    = !rst && tx_valid_o && tx_ready;
    if (rx_fire_n) begin
      pend_op     = rx_data;
      got_res     = 0;
      last_rx_cyc = cyc;
    end
    if (issue_fire_n) begin
      chk("mac_operands", {mac_a, mac_b, mac_c}, pend_op);
      last_issue_cyc = cyc;
    end
    if (res_fire_n) got_res = 1;
    if (tx_fire_n) begin
      if (exp_q.size() == 0) chk("tx_unexpected", tx_data, 0);
      else chk("tx_data", tx_data, exp_q.pop_front());
      last_tx_data = tx_data;
      last_tx_cyc  = cyc;
      tx_cyc_q.push_back(cyc);
      tx_count++;
      model_pkt++;
      if (!got_res && model_to < 255) model_to++;
    end
    hold_tx  = !rst && tx_valid_o && !tx_ready;
    held_tx  = tx_data;
    hold_mac = !rst && mac_valid_o && !mac_rdy;
    held_ops = {mac_a, mac_b, mac_c};
  end

  // RX source: presents queued packets back to back.
  always begin
    @(posedge clk); #1;
    if (rx_fire_n && rx_q.size() > 0) void'(rx_q.pop_front());
    if (rx_q.size() > 0) begin
      rx_valid = 1'b1;
      rx_data  = rx_q[0];
    end else begin
      rx_valid = 1'b0;
    end
  end

  // MAC model: answers mac_delay cycles after issue with the queued result.
  int mac_delay = 0, cd = 0;
  bit mac_never = 0, stray = 0, pend = 0, owned = 0;
  always begin
    @(posedge clk); #1;
    if (rst) begin
      mac_vld = 1'b0;
      pend    = 0;
      owned   = 0;
    end else if (stray) begin
      mac_vld    = 1'b1;
      mac_result = 32'hDEADBEEF;
    end else begin
      if (res_fire_n || !owned) begin
        mac_vld = 1'b0;
        owned   = 0;
      end
      if (issue_fire_n && !mac_never) begin
        pend = 1;
        cd   = mac_delay;
      end
      if (pend) begin
        if (cd == 0) begin
          mac_vld    = 1'b1;
          mac_result = (res_q.size() > 0) ? res_q.pop_front() : 32'h0;
          owned      = 1;
          pend       = 0;
        end else begin
          cd--;
        end
      end
    end
  end

  task automatic push_vec(input logic [127:0] v);
    rx_q.push_back(v[127:32]);
    res_q.push_back(v[31:0]);
    exp_q.push_back(v[31:0]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_count < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("tx_arrived", tx_count >= n, 1);
    repeat (2) @(negedge clk);
  endtask

  // {A, B, C, A*B+C}
  logic [127:0] vec [6];

  initial begin
    int k, n0;
    vec[0] = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000}; // 1*2+3=5
    vec[1] = {32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000}; // 2*3+1=7
    vec[2] = {32'h40400000, 32'h40400000, 32'h00000000, 32'h41100000}; // 3*3+0=9
    vec[3] = {32'hBF800000, 32'h40000000, 32'h40400000, 32'h3F800000}; // -1*2+3=1
    vec[4] = {32'h40800000, 32'h3F000000, 32'h3F800000, 32'h40400000}; // 4*0.5+1=3
    vec[5] = {32'hC0000000, 32'hC0000000, 32'hC0800000, 32'h00000000}; // -2*-2-4=0

    repeat (3) @(negedge clk);
    chk("rst_flags", {rx_ready_o, mac_valid_o, mac_ready_o, tx_valid_o, busy_o}, 0);
    chk("rst_operands", {mac_a, mac_b, mac_c}, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_counters", {pkt_cnt, to_cnt}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("rx_ready_before_edge", rx_ready_o, 0);
    @(negedge clk); chk("rx_ready_first_edge", rx_ready_o, 1);

    // Basic packet, result 3 cycles after issue
    mac_delay = 2;
    push_vec(vec[0]);
    wait_tx(1, 50);
    chk("basic_tx_word", last_tx_data, 32'h40A00000);
    chk("basic_pkt_cnt", pkt_cnt, 1);

    // Minimum latency with everything ready
    mac_delay = 0;
    push_vec(vec[1]);
    wait_tx(2, 50);
    chk("min_latency", last_tx_cyc - last_rx_cyc, 4);
    chk("latency_pkt_cnt", pkt_cnt, 2);

    // TX back-pressure for 10 cycles, with the next packet stalled upstream
    @(posedge clk); #1 tx_ready = 1'b0;
    push_vec(vec[2]);
    k = 0;
    while (!tx_valid_o && k < 50) begin @(negedge clk); k++; end
    chk("stall_tx_valid", tx_valid_o, 1);
    push_vec(vec[3]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_rx_ready", rx_ready_o, 0);
      chk("stall_tx_data", tx_data, 32'h41100000);
    end
    chk("stall_no_tx", tx_count, 2);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_tx(4, 50);
    chk("stalled_pkt_result", last_tx_data, 32'h3F800000);
    chk("stall_pkt_cnt", pkt_cnt, 4);

    // Stray MAC result while idle must be ignored
    @(posedge clk); #1 stray = 1;
    repeat (3) @(negedge clk);
    chk("stray_busy", busy_o, 0);
    chk("stray_mac_ready", mac_ready_o, 0);
    @(posedge clk); #1 stray = 0;
    repeat (3) @(negedge clk);
    chk("stray_no_tx", tx_count, 4);

    // Reset in WAIT abandons the packet
    mac_never = 1;
    rx_q.push_back(vec[4][127:32]);
    k = 0;
    while (!mac_ready_o && k < 50) begin @(negedge clk); k++; end
    chk("reached_wait", mac_ready_o, 1);
    @(negedge clk); #3 rst = 1'b1;
    #1;
    chk("async_rst_flags", {rx_ready_o, mac_valid_o, mac_ready_o, tx_valid_o, busy_o}, 0);
    chk("async_rst_data", {mac_a, mac_b, mac_c, tx_data}, 0);
    chk("async_rst_cnt", pkt_cnt, 0);
    repeat (3) @(negedge clk);
    chk("rst_no_tx", tx_count, 4);
    @(posedge clk); #1 rst = 1'b0;
    mac_never = 0;
    push_vec(vec[4]);
    wait_tx(5, 50);
    chk("post_rst_word", last_tx_data, 32'h40400000);
    chk("post_rst_pkt_cnt", pkt_cnt, 1);

    // Back-to-back burst: one TX per 5 cycles, in order; 4-bit twin wraps
    n0 = tx_cyc_q.size();
    for (int i = 0; i < 18; i++) push_vec(vec[i % 6]);
    wait_tx(23, 400);
    for (int i = n0 + 1; i < n0 + 18; i++)
      chk("b2b_period", tx_cyc_q[i] - tx_cyc_q[i-1], 5);
    chk("burst_pkt_cnt", pkt_cnt, 19);
    chk("wrap_pkt_cnt_w4", w_pkt_cnt, 3);

`ifdef FP32_MAC_CTRL_TIMEOUT_EN
    // No result: quiet NaN after 8 WAIT cycles
    mac_never = 1;
    rx_q.push_back(vec[0][127:32]);
    exp_q.push_back(32'h7FC00000);
    wait_tx(24, 60);
    chk("timeout_word", last_tx_data, 32'h7FC00000);
    chk("timeout_count", to_cnt, 1);
    chk("timeout_timing", last_tx_cyc - last_issue_cyc, 10);
    chk("timeout_idle", busy_o, 0);
    // Result on the expiry edge wins
    mac_never = 0;
    mac_delay = 7;
    push_vec(vec[1]);
    wait_tx(25, 60);
    chk("expiry_result_wins", last_tx_data, 32'h40E00000);
    chk("expiry_no_timeout", to_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/fp32_mac_ctrl.md
FP32_MAC_CTRL -- requirements
Module: fp32_mac_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent waiting for a MAC result, range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 16: width of the packet counter.
REQ-003 SHALL have port CLK_I, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_I, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports RX_VALID_I (input, 1), RX_READY_O (output, 1) and RX_DATA_I (input, 96): the receive packet {A[95:64], B[63:32], C[31:0]}.
REQ-006 SHALL have ports MAC_VALID_O (output, 1), MAC_READY_I (input, 1), MAC_A_O, MAC_B_O and MAC_C_O (outputs, 32 each): the operand issue channel.
REQ-007 SHALL have ports MAC_VALID_I (input, 1), MAC_READY_O (output, 1) and MAC_RESULT_I (input, 32): the result channel, carrying A*B+C.
REQ-008 SHALL have ports TX_VALID_O (output, 1), TX_READY_I (input, 1) and TX_DATA_O (output, 32): the transmit channel.
REQ-009 SHALL have status outputs BUSY_O (1 bit), PKT_CNT_O (CNT_W bits) and TIMEOUT_CNT_O (8 bits).

Function
REQ-010 SHALL treat a transfer on any channel as occurring only on a rising edge where valid and ready are both 1.
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT and SEND.
REQ-012 IDLE SHALL drive RX_READY_O=1; on an RX transfer it SHALL latch A, B and C into operand registers and move to ISSUE.
REQ-013 ISSUE SHALL hold MAC_VALID_O=1 with operands stable until MAC_READY_I=1, then move to WAIT.
REQ-014 WAIT SHALL drive MAC_READY_O=1; on a result transfer it SHALL latch MAC_RESULT_I into the result register and move to SEND.
REQ-015 SEND SHALL hold TX_VALID_O=1 with TX_DATA_O stable until TX_READY_I=1, then increment PKT_CNT_O and return to IDLE.
REQ-016 Minimum latency SHALL be 4 cycles from RX transfer to TX transfer, with MAC_READY_I, MAC_VALID_I and TX_READY_I all continuously 1.
REQ-017 RX_READY_O SHALL be 0 in all states except IDLE: exactly one packet in flight, no buffering.
REQ-018 MAC_VALID_O SHALL be 1 only in ISSUE, MAC_READY_O only in WAIT and TX_VALID_O only in SEND.
REQ-019 A MAC_VALID_I pulse in any state other than WAIT SHALL be ignored.
REQ-020 BUSY_O SHALL be 1 whenever the state is not IDLE.
REQ-021 PKT_CNT_O SHALL wrap from 2^CNT_W-1 to 0.
REQ-022 TIMEOUT_CNT_O SHALL saturate at 255.
REQ-023 An RX_VALID_I arriving while the block is not in IDLE SHALL stall upstream (RX_READY_O=0); it SHALL NOT be dropped.

Reset
REQ-024 While RST_I=1, regardless of clock, the block SHALL force state to IDLE, clear all operand and result registers and counters, and drive RX_READY_O, MAC_VALID_O, MAC_READY_O, TX_VALID_O and BUSY_O to 0.
REQ-025 MAC_A_O, MAC_B_O, MAC_C_O and TX_DATA_O SHALL reset to 32'h0.
REQ-026 A reset asserted mid-transaction SHALL abandon the in-flight packet without emitting any TX word.
REQ-027 After RST_I deasserts, RX_READY_O SHALL become 1 from the first rising edge.

Configuration
REQ-028 With macro FP32_MAC_CTRL_TIMEOUT_EN defined, a counter SHALL run in WAIT.
REQ-029 With the macro defined, if no result transfer occurs within TIMEOUT_CYCLES cycles of entering WAIT, the FSM SHALL load 32'h7FC00000 (quiet NaN) as the result, increment TIMEOUT_CNT_O and move to SEND.
REQ-030 With the macro defined, a result arriving on the same edge the count expires SHALL take priority over the timeout.
REQ-031 With the macro undefined, WAIT SHALL wait indefinitely and TIMEOUT_CNT_O SHALL be tied to 0.

Verification
REQ-032 Send RX {3F800000, 40000000, 40400000} with the MAC model returning 40A00000 after 3 cycles -> TX_DATA_O=40A00000 and PKT_CNT_O=1.
REQ-033 Hold TX_READY_I=0 for 10 cycles during SEND -> TX_VALID_O stays 1, TX_DATA_O stays stable, RX_READY_O stays 0; exactly one TX transfer occurs.
REQ-034 Present back-to-back RX packets with all ready inputs 1 -> one TX transfer every 5 cycles, in order, none lost.
REQ-035 With FP32_MAC_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no MAC result -> TX word 7FC00000 at the timeout, TIMEOUT_CNT_O=1, block returns to IDLE.
REQ-036 Assert RST_I during WAIT -> all outputs 0 asynchronously, no TX transfer; the next packet processes normally.
REQ-037 Preload PKT_CNT_O to FFFF, then process one packet -> PKT_CNT_O=0000.
